// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types.
//   ramstate_t  : handshake state reported by the single-ported RAM
//   word_t      : 32-bit machine word
//   arb_state_t : mem_arbiter FSM states
//   is_access() : true while the arbiter owns the RAM bus
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IACC  = 3'd1,
    DACC  = 3'd2,
    IDONE = 3'd3,
    DDONE = 3'd4
  } arb_state_t;

  localparam word_t ERR_WORD_DEFAULT = 32'hBAD1BAD1;

  function automatic logic is_access(input arb_state_t s);
    return (s == IACC) || (s == DACC);
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Per-access watchdog for mem_arbiter.
//   CLK     : system clock, rising edge
//   nRST    : asynchronous active-low reset
//   clear   : synchronous clear of the cycle count
//   enable  : count one cycle of an in-flight access
//   expired : high in the cycle where the count has reached TIMEOUT-1,
//             i.e. this is the last cycle the access may wait
// The count saturates at TIMEOUT and never wraps.
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] CNT_MAX = W'(TIMEOUT);
  localparam logic [W-1:0] CNT_TC  = W'(TIMEOUT - 1);

  logic [W-1:0] wdog;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wdog <= '0;
    end else if (clear) begin
      wdog <= '0;
    end else if (enable && (wdog != CNT_MAX)) begin
      wdog <= wdog + W'(1);
    end
  end

  assign expired = enable && (wdog == CNT_TC);

endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter in front of a single-ported RAM.
//   CLK, nRST            : clock (rising edge), async active-low reset
//   iRen, iaddr          : instruction fetch request, held until iHit
//   dRen, dWen, daddr,
//   dstore               : data read/write request, held until dHit
//   iHit/iload           : one-cycle fetch completion and instruction word
//   dHit/dload           : one-cycle data completion and load word
//   ramREN, ramWEN,
//   ramaddr, ramstore    : RAM request side
//   ramload, ramstate    : RAM response side (FREE/BUSY/ACCESS/ERROR)
//   memerr               : sticky error flag, cleared only by reset
//
// state | meaning
// IDLE  | no access; grant decision on next edge
// IACC  | instruction fetch in flight on RAM
// DACC  | data read or write in flight on RAM
// IDONE | iHit pulse, iload valid
// DDONE | dHit pulse, dload valid
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = ERR_WORD_DEFAULT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iRen,
  input  logic [31:0] iaddr,
  input  logic        dRen,
  input  logic        dWen,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iHit,
  output logic        dHit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  arb_state_t state, next_state;
  ramstate_t  rs;

  word_t addr_q, store_q, load_q;
  logic  wr_q;
  logic  last_was_d;
  logic  memerr_q;

  logic d_req, i_req;
  logic grant_d, grant_i;
  logic capture, fail;
  logic wdog_expired;

  assign rs    = ramstate_t'(ramstate);
  assign d_req = dRen | dWen;
  assign i_req = iRen;

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (state == IDLE),
    .enable  (is_access(state)),
    .expired (wdog_expired)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    capture    = 1'b0;
    fail       = 1'b0;
    case (state)
      IDLE: begin
        // Data normally wins; after a data access an instruction fetch
        // gets exactly one turn, bounding fetch starvation to one access.
        if (d_req && (!i_req || !last_was_d)) begin
          grant_d    = 1'b1;
          next_state = DACC;
        end else if (i_req) begin
          grant_i    = 1'b1;
          next_state = IACC;
        end
      end
      IACC, DACC: begin
        // A real answer in the final watchdog cycle still counts as good.
        if (rs == ACCESS) begin
          capture    = 1'b1;
          next_state = (state == IACC) ? IDONE : DDONE;
        end else if ((rs == ERROR) || wdog_expired) begin
          fail       = 1'b1;
          next_state = (state == IACC) ? IDONE : DDONE;
        end
      end
      IDONE, DDONE: next_state = IDLE;
      default:      next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q     <= '0;
      store_q    <= '0;
      wr_q       <= 1'b0;
      load_q     <= '0;
      last_was_d <= 1'b0;
      memerr_q   <= 1'b0;
    end else begin
      if (grant_d) begin
        addr_q  <= daddr;
        store_q <= dstore;
        wr_q    <= dWen;
        // Read and write together is a requester bug; the write proceeds.
        if (dRen && dWen) memerr_q <= 1'b1;
      end else if (grant_i) begin
        addr_q  <= iaddr;
        store_q <= '0;
        wr_q    <= 1'b0;
      end
      if (capture) begin
        load_q <= ramload;
      end else if (fail) begin
        load_q   <= ERR_WORD;
        memerr_q <= 1'b1;
      end
      if ((state == IDONE) || (state == DDONE)) begin
        last_was_d <= (state == DDONE);
      end
    end
  end

  // Strobes decode straight from the state register so they fall together
  // with an asynchronous reset.
  always_comb begin
    ramREN   = (state == IACC) || ((state == DACC) && !wr_q);
    ramWEN   = (state == DACC) && wr_q;
    ramaddr  = is_access(state) ? addr_q : '0;
    ramstore = ((state == DACC) && wr_q) ? store_q : '0;
  end

  assign iHit   = (state == IDONE);
  assign dHit   = (state == DDONE);
  assign iload  = (state == IDONE) ? load_q : '0;
  assign dload  = (state == DDONE) ? load_q : '0;
  assign memerr = memerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACC = 2'd2, R_ERR = 2'd3;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iRen = 1'b0, dRen = 1'b0, dWen = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = R_FREE;
  logic        iHit, dHit, ramREN, ramWEN, memerr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.TIMEOUT(8), .ERR_WORD(32'hBAD1BAD1)) dut (
    .CLK(CLK), .nRST(nRST),
    .iRen(iRen), .iaddr(iaddr),
    .dRen(dRen), .dWen(dWen), .daddr(daddr), .dstore(dstore),
    .iHit(iHit), .dHit(dHit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    iRen = 0; dRen = 0; dWen = 0; ramstate = R_FREE;
    @(negedge CLK); nRST = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({iHit, dHit, ramREN, ramWEN, memerr} !== 5'b0 || ramaddr !== 0 || iload !== 0) begin
      n_fail++; $display("FAIL reset_outputs: got hit/ren/wen/err=%b addr=%h required all 0",
                         {iHit, dHit, ramREN, ramWEN, memerr}, ramaddr);
    end
    @(negedge CLK); nRST = 1'b1;
    tick();
    // start a write that the RAM keeps busy, then reset in the middle of it
    dWen = 1; daddr = 32'h100; dstore = 32'h5555AAAA; ramstate = R_BUSY;
    tick();
    tick();
    n_checks++;
    if (ramWEN !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_wen: got %b required 1", ramWEN);
    end
    #3 nRST = 1'b0;
    #1;
    n_checks++;
    if ({ramWEN, ramREN, iHit, dHit, memerr} !== 5'b0 || ramaddr !== 0 || ramstore !== 0) begin
      n_fail++; $display("FAIL reset_midacc: got wen/ren/hits/err=%b addr=%h store=%h required 0",
                         {ramWEN, ramREN, iHit, dHit, memerr}, ramaddr, ramstore);
    end
    dWen = 0; ramstate = R_FREE;
    @(negedge CLK); nRST = 1'b1;
    tick();
    n_checks++;
    if ({ramWEN, ramREN, iHit, dHit, memerr} !== 5'b0) begin
      n_fail++; $display("FAIL reset_idle: got %b required 00000", {ramWEN, ramREN, iHit, dHit, memerr});
    end
  endtask

  task automatic test_alternate();
    logic seq [4];
    int   nh = 0;
    logic both = 0;
    iRen = 1; iaddr = 32'h80; dRen = 1; daddr = 32'h200;
    ramstate = R_ACC; ramload = 32'h00001234;
    for (int k = 0; k < 30 && nh < 4; k++) begin
      tick();
      if (iHit && dHit) both = 1;
      if (dHit) begin seq[nh] = 1'b1; nh++; end
      else if (iHit) begin seq[nh] = 1'b0; nh++; end
    end
    iRen = 0; dRen = 0; ramstate = R_FREE;
    n_checks++;
    if (nh != 4) begin
      n_fail++; $display("FAIL alt_hits: got %0d hits required 4 within budget", nh);
    end else begin
      n_checks++;
      if ({seq[0], seq[1], seq[2], seq[3]} !== 4'b1010) begin
        n_fail++; $display("FAIL alt_order: got %b (1=D) required 1010",
                           {seq[0], seq[1], seq[2], seq[3]});
      end
    end
    n_checks++;
    if (both !== 1'b0) begin
      n_fail++; $display("FAIL alt_exclusive: iHit and dHit high together");
    end
    tick();
  endtask

  task automatic test_ifetch();
    int   ren_cnt = 0;
    logic dseen = 0, addr_bad = 0;
    iRen = 1; iaddr = 32'h40; ramstate = R_BUSY; ramload = 32'h0;
    for (int k = 0; k < 20 && !iHit; k++) begin
      tick();
      if (ramREN) ren_cnt++;
      if (dHit) dseen = 1;
      if (ramREN && ramaddr !== 32'h40) addr_bad = 1;
      if (ren_cnt == 4 && ramstate == R_BUSY) begin
        ramstate = R_ACC; ramload = 32'h8C220004;
      end
    end
    n_checks++;
    if (iHit !== 1'b1) begin
      n_fail++; $display("FAIL ifetch_hit: got %b required 1 within budget", iHit);
    end
    n_checks++;
    if (ren_cnt != 4 || addr_bad) begin
      n_fail++; $display("FAIL ifetch_ren: got %0d cycles addr_bad=%b required 4 at 00000040", ren_cnt, addr_bad);
    end
    n_checks++;
    if (iload !== 32'h8C220004 || ramREN !== 1'b0 || dseen) begin
      n_fail++; $display("FAIL ifetch_data: got iload=%h ren=%b dHit_seen=%b required 8c220004 0 0",
                         iload, ramREN, dseen);
    end
    iRen = 0; ramstate = R_FREE;
    tick();
    n_checks++;
    if (iHit !== 1'b0 || iload !== 0) begin
      n_fail++; $display("FAIL ifetch_pulse: got iHit=%b iload=%h required 0", iHit, iload);
    end
  endtask

  task automatic test_dwrite();
    dWen = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = R_ACC;
    tick();
    n_checks++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hDEADBEEF || ramaddr !== 32'h100 || dHit !== 1'b0) begin
      n_fail++; $display("FAIL dwrite_bus: got wen=%b ren=%b store=%h addr=%h dHit=%b required 1 0 deadbeef 00000100 0",
                         ramWEN, ramREN, ramstore, ramaddr, dHit);
    end
    tick();
    n_checks++;
    if (dHit !== 1'b1 || ramWEN !== 1'b0 || iHit !== 1'b0 || memerr !== 1'b0) begin
      n_fail++; $display("FAIL dwrite_hit: got dHit=%b wen=%b iHit=%b err=%b required 1 0 0 0",
                         dHit, ramWEN, iHit, memerr);
    end
    dWen = 0; ramstate = R_FREE;
    tick();
  endtask

  task automatic test_derror();
    dRen = 1; daddr = 32'h300; ramstate = R_ERR; ramload = 32'h11111111;
    tick();
    n_checks++;
    if (ramREN !== 1'b1 || ramWEN !== 1'b0 || memerr !== 1'b0) begin
      n_fail++; $display("FAIL derror_bus: got ren=%b wen=%b err=%b required 1 0 0", ramREN, ramWEN, memerr);
    end
    tick();
    n_checks++;
    if (dHit !== 1'b1 || dload !== BAD || memerr !== 1'b1) begin
      n_fail++; $display("FAIL derror_hit: got dHit=%b dload=%h err=%b required 1 bad1bad1 1", dHit, dload, memerr);
    end
    dRen = 0; ramstate = R_FREE;
    tick();
  endtask

  task automatic test_timeout();
    int ren_cnt = 0;
    apply_reset();
    n_checks++;
    if (memerr !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pre_err: got %b required 0", memerr);
    end
    iRen = 1; iaddr = 32'h44; ramstate = R_BUSY;
    for (int k = 0; k < 30 && !iHit; k++) begin
      tick();
      if (ramREN) ren_cnt++;
    end
    n_checks++;
    if (iHit !== 1'b1 || ren_cnt != 8 || iload !== BAD || memerr !== 1'b1) begin
      n_fail++; $display("FAIL timeout_hit: got iHit=%b cycles=%0d iload=%h err=%b required 1 8 bad1bad1 1",
                         iHit, ren_cnt, iload, memerr);
    end
    iRen = 0; ramstate = R_FREE;
    tick();
    dRen = 1; daddr = 32'h10; ramstate = R_ACC; ramload = 32'h00000077;
    tick();
    tick();
    n_checks++;
    if (dHit !== 1'b1 || dload !== 32'h77 || memerr !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got dHit=%b dload=%h err=%b required 1 00000077 1", dHit, dload, memerr);
    end
    dRen = 0; ramstate = R_FREE;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alternate();
    test_ifetch();
    test_dwrite();
    test_derror();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
